// File: rtl/vec_seq_pkg.sv
// Shared types and constants for the vector ALU sequencer.
package vec_seq_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned VEC_W  = LANES * DATA_W;
    localparam int unsigned VX_W   = 56;

    localparam logic [2:0] VOP_G = 3'b001;
    localparam logic [2:0] VOP_A = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        CAP_A,
        RD_B,
        CAP_B,
        EXEC,
        WR,
        DONE
    } seq_state_e;

endpackage

// File: rtl/vec_seq_addr_gen.sv
// Chunk index register plus base+idx address generation (wraps at ADDR_W bits).
module vec_seq_addr_gen #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] src_a_i,
    input  logic [ADDR_W-1:0] src_b_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o,
    output logic [ADDR_W-1:0] addr_d_o,
    output logic              last_o
);

    logic [LEN_W-1:0]  idx_q;
    logic [LEN_W-1:0]  idx_d;
    logic [ADDR_W-1:0] idx_ext;

    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = '0;
        end else if (adv_i) begin
            idx_d = idx_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Addresses follow the next index so the owner can register them on the same edge idx advances.
    assign idx_ext  = ADDR_W'(idx_d);
    assign addr_a_o = src_a_i + idx_ext;
    assign addr_b_o = src_b_i + idx_ext;
    assign addr_d_o = dst_i + idx_ext;
    assign last_o   = (idx_q == (len_i - LEN_W'(1)));

endmodule

// File: rtl/vec_alu_sequencer.sv
// Command-driven sequencer feeding the combinational vec_ALU over a shared memory port.
// Define VEC_SEQ_PERF_EN to add saturating perf_cycles / perf_stall counters.
module vec_alu_sequencer
    import vec_seq_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic                      cmd_vcsub,
    input  logic [VX_W-1:0]           cmd_vx,
    input  logic [ADDR_W-1:0]         cmd_src_a,
    input  logic [ADDR_W-1:0]         cmd_src_b,
    input  logic [ADDR_W-1:0]         cmd_dst,
    input  logic [LEN_W-1:0]          cmd_len,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LANES*DATA_W-1:0]   mem_wdata,
    input  logic                      mem_gnt,
    input  logic [LANES*DATA_W-1:0]   mem_rdata,
    output logic [2:0]                alu_op,
    output logic                      alu_vcsub,
    output logic [VX_W-1:0]           alu_vx,
    output logic [LANES*DATA_W-1:0]   alu_a,
    output logic [LANES*DATA_W-1:0]   alu_b,
    input  logic [LANES*DATA_W-1:0]   alu_out,
    output logic                      busy,
    output logic                      done
`ifdef VEC_SEQ_PERF_EN
    ,
    output logic [31:0]               perf_cycles,
    output logic [31:0]               perf_stall
`endif
);

    seq_state_e                state_q;
    logic                      ready_q, busy_q, done_q, req_q, we_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [2:0]                op_q;
    logic                      vcsub_q;
    logic [VX_W-1:0]           vx_q;
    logic [ADDR_W-1:0]         src_a_q, src_b_q, dst_q;
    logic [LEN_W-1:0]          len_q;
    logic [LANES*DATA_W-1:0]   reg_a_q, reg_b_q, reg_r_q;

    logic                      load, adv, last;
    logic [ADDR_W-1:0]         addr_a, addr_b, addr_d;

    assign load = (state_q == IDLE) && cmd_valid;
    assign adv  = (state_q == WR) && mem_gnt && !last;

    vec_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .adv_i    (adv),
        .src_a_i  (src_a_q),
        .src_b_i  (src_b_q),
        .dst_i    (dst_q),
        .len_i    (len_q),
        .addr_a_o (addr_a),
        .addr_b_o (addr_b),
        .addr_d_o (addr_d),
        .last_o   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            op_q    <= '0;
            vcsub_q <= 1'b0;
            vx_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            reg_r_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        vcsub_q <= cmd_vcsub;
                        vx_q    <= cmd_vx;
                        src_a_q <= cmd_src_a;
                        src_b_q <= cmd_src_b;
                        dst_q   <= cmd_dst;
                        len_q   <= cmd_len;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (cmd_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // Base registers are not loaded yet, so the first address comes from the command.
                            state_q <= RD_A;
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                            addr_q  <= cmd_src_a;
                        end
                    end
                end
                RD_A: begin
                    if (mem_gnt) begin
                        state_q <= CAP_A;
                        req_q   <= 1'b0;
                    end
                end
                CAP_A: begin
                    reg_a_q <= mem_rdata;
                    state_q <= RD_B;
                    req_q   <= 1'b1;
                    addr_q  <= addr_b;
                end
                RD_B: begin
                    if (mem_gnt) begin
                        state_q <= CAP_B;
                        req_q   <= 1'b0;
                    end
                end
                CAP_B: begin
                    reg_b_q <= mem_rdata;
                    state_q <= EXEC;
                end
                EXEC: begin
                    reg_r_q <= alu_out;
                    state_q <= WR;
                    req_q   <= 1'b1;
                    we_q    <= 1'b1;
                    addr_q  <= addr_d;
                end
                WR: begin
                    if (mem_gnt) begin
                        we_q <= 1'b0;
                        if (last) begin
                            state_q <= DONE;
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD_A;
                            addr_q  <= addr_a;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = reg_r_q;
    assign alu_op    = op_q;
    assign alu_vcsub = vcsub_q;
    assign alu_vx    = vx_q;
    assign alu_a     = reg_a_q;
    assign alu_b     = reg_b_q;

`ifdef VEC_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy_q && (perf_cycles_q != '1)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (req_q && !mem_gnt && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
